// File: rtl/adpcm_capture_sequencer_pkg.sv
// Shared types and constants for the ADPCM capture sequencer slice.
package adpcm_pkg;

    // Sequencer operating states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam int CODE_W = 4;
    localparam int BYTE_W = 8;
    localparam logic [7:0] PAD_BYTE = 8'h00;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adpcm_capture_sequencer_if.sv
// Byte stream output of the capture sequencer: valid/ready with frame marker.
interface adpcm_capture_sequencer_if;
    import adpcm_pkg::*;

    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/adpcm_byte_fifo.sv
// Small synchronous FIFO holding {last, data} entries; head is presented
// continuously and reads as zero while empty.
module adpcm_byte_fifo
    import adpcm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             one_left
);

    localparam int AW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == (AW+1)'(0));
    assign one_left  = (count_r == (AW+1)'(1));
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Head entry, masked to zero when nothing is stored
    always_comb begin
        rdata = {WIDTH{1'b0}};
        if (!empty) begin
            rdata = mem_r[rd_ptr_r];
        end else begin
            rdata = {WIDTH{1'b0}};
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= (wr_ptr_r == AW'(DEPTH-1)) ? {AW{1'b0}} : wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == AW'(DEPTH-1)) ? {AW{1'b0}} : rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/adpcm_capture_sequencer.sv
// Capture sequencer: PDM clock/strobe generation, warm-up discard, nibble
// packing, framing with end-of-capture padding, and buffered byte output.
module adpcm_capture_sequencer
    import adpcm_pkg::*;
#(
    parameter int PDM_DIV    = 4,
    parameter int DECIM      = 64,
    parameter int WARMUP     = 4,
    parameter int FRAME_LEN  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              pdm_clk_out,
    output logic              pdm_clk_en,
    output logic              dec_strobe,
    output logic              blk_en,
    input  logic              enc_valid,
    input  logic [CODE_W-1:0] enc_code,
    output logic              overflow,
    adpcm_capture_sequencer_if.master out_bus
);

    localparam int DIV_W = cnt_width(PDM_DIV);
    localparam int BIT_W = cnt_width(DECIM);
    localparam int WRM_W = cnt_width(WARMUP + 1);
    localparam int BYC_W = cnt_width(FRAME_LEN);

    state_t             state_r, state_next_s;
    logic [DIV_W-1:0]   div_cnt_r, div_next_s;
    logic [BIT_W-1:0]   bit_cnt_r, bit_next_s;
    logic [WRM_W-1:0]   warm_cnt_r, warm_next_s;
    logic [BYC_W-1:0]   byte_cnt_r, byte_next_s;
    logic [CODE_W-1:0]  nib_r, nib_next_s;
    logic               pend_r, pend_next_s;
    logic               ovf_next_s;
    logic               busy_r, pdm_clk_out_r, pdm_clk_en_r, dec_strobe_r, blk_en_r, overflow_r;

    logic               code_fire_s;
    logic               byte_last_s;
    logic [BYC_W-1:0]   byte_inc_s;
    logic               active_now_s;
    logic               active_next_s;
    logic               push_s;
    logic [BYTE_W-1:0]  push_data_s;
    logic               push_last_s;
    logic               pop_s;
    logic [BYTE_W:0]    head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               fifo_one_s;

    assign code_fire_s   = blk_en_r && enc_valid;
    assign byte_last_s   = (byte_cnt_r == BYC_W'(FRAME_LEN-1));
    assign byte_inc_s    = byte_last_s ? {BYC_W{1'b0}} : byte_cnt_r + BYC_W'(1);
    assign active_now_s  = (state_r == ST_WARMUP) || (state_r == ST_RUN);
    assign pop_s         = out_bus.out_valid && out_bus.out_ready;

    // Next-state, counter, packing and drain decisions
    always_comb begin
        state_next_s = state_r;
        div_next_s   = div_cnt_r;
        bit_next_s   = bit_cnt_r;
        warm_next_s  = warm_cnt_r;
        byte_next_s  = byte_cnt_r;
        nib_next_s   = nib_r;
        pend_next_s  = pend_r;
        ovf_next_s   = overflow_r;
        push_s       = 1'b0;
        push_data_s  = PAD_BYTE;
        push_last_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_next_s = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
                    bit_next_s   = {BIT_W{1'b0}};
                    warm_next_s  = {WRM_W{1'b0}};
                    byte_next_s  = {BYC_W{1'b0}};
                    pend_next_s  = 1'b0;
                    ovf_next_s   = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WARMUP: begin
                if (stop) begin
                    state_next_s = ST_DRAIN;
                end else if (code_fire_s) begin
                    if (warm_cnt_r == WRM_W'(WARMUP-1)) begin
                        state_next_s = ST_RUN;
                    end else begin
                        warm_next_s = warm_cnt_r + WRM_W'(1);
                    end
                end else begin
                    state_next_s = ST_WARMUP;
                end
            end
            ST_RUN: begin
                // A code arriving with stop is still packed: the block was enabled
                if (code_fire_s) begin
                    if (!pend_r) begin
                        nib_next_s  = enc_code;
                        pend_next_s = 1'b1;
                    end else begin
                        push_s      = 1'b1;
                        push_data_s = {enc_code, nib_r};
                        push_last_s = byte_last_s;
                        byte_next_s = byte_inc_s;
                        pend_next_s = 1'b0;
                    end
                end else begin
                    pend_next_s = pend_r;
                end
                if (stop) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pend_r) begin
                    push_s      = 1'b1;
                    push_data_s = {{CODE_W{1'b0}}, nib_r};
                    push_last_s = byte_last_s;
                    byte_next_s = byte_inc_s;
                    pend_next_s = 1'b0;
                end else if (byte_cnt_r != {BYC_W{1'b0}}) begin
                    push_s      = 1'b1;
                    push_data_s = PAD_BYTE;
                    push_last_s = byte_last_s;
                    byte_next_s = byte_inc_s;
                end else if (fifo_empty_s || (fifo_one_s && pop_s)) begin
                    // Leave as the final byte departs so busy drops right after it
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        active_next_s = (state_next_s == ST_WARMUP) || (state_next_s == ST_RUN);

        if (active_now_s && active_next_s) begin
            div_next_s = (div_cnt_r == DIV_W'(PDM_DIV-1)) ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
            if (pdm_clk_en_r) begin
                bit_next_s = (bit_cnt_r == BIT_W'(DECIM-1)) ? {BIT_W{1'b0}} : bit_cnt_r + BIT_W'(1);
            end else begin
                bit_next_s = bit_cnt_r;
            end
        end else begin
            div_next_s = {DIV_W{1'b0}};
        end

        // A dropped byte has already advanced byte_cnt above, keeping frames aligned
        if (push_s && fifo_full_s && !pop_s) begin
            ovf_next_s = 1'b1;
        end else begin
            ovf_next_s = ovf_next_s;
        end
    end

    // State, counters and registered control outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            div_cnt_r     <= {DIV_W{1'b0}};
            bit_cnt_r     <= {BIT_W{1'b0}};
            warm_cnt_r    <= {WRM_W{1'b0}};
            byte_cnt_r    <= {BYC_W{1'b0}};
            nib_r         <= {CODE_W{1'b0}};
            pend_r        <= 1'b0;
            overflow_r    <= 1'b0;
            busy_r        <= 1'b0;
            pdm_clk_out_r <= 1'b0;
            pdm_clk_en_r  <= 1'b0;
            dec_strobe_r  <= 1'b0;
            blk_en_r      <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            div_cnt_r     <= div_next_s;
            bit_cnt_r     <= bit_next_s;
            warm_cnt_r    <= warm_next_s;
            byte_cnt_r    <= byte_next_s;
            nib_r         <= nib_next_s;
            pend_r        <= pend_next_s;
            overflow_r    <= ovf_next_s;
            busy_r        <= (state_next_s != ST_IDLE);
            pdm_clk_out_r <= active_next_s && (div_next_s < DIV_W'(PDM_DIV/2));
            pdm_clk_en_r  <= active_next_s && (div_next_s == DIV_W'(PDM_DIV-1));
            dec_strobe_r  <= active_next_s && (div_next_s == DIV_W'(PDM_DIV-1))
                             && (bit_next_s == BIT_W'(DECIM-1));
            blk_en_r      <= active_next_s;
        end
    end

    adpcm_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .wdata    ({push_last_s, push_data_s}),
        .pop      (pop_s),
        .rdata    (head_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .one_left (fifo_one_s)
    );

    assign busy              = busy_r;
    assign pdm_clk_out       = pdm_clk_out_r;
    assign pdm_clk_en        = pdm_clk_en_r;
    assign dec_strobe        = dec_strobe_r;
    assign blk_en            = blk_en_r;
    assign overflow          = overflow_r;
    assign out_bus.out_data  = head_s[BYTE_W-1:0];
    assign out_bus.out_last  = head_s[BYTE_W];
    assign out_bus.out_valid = !fifo_empty_s;

endmodule

// File: tb/tb_adpcm_capture_sequencer.sv
// Directed bench for adpcm_capture_sequencer with hand-computed expectations.
module tb_adpcm_capture_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       busy;
    logic       pdm_clk_out;
    logic       pdm_clk_en;
    logic       dec_strobe;
    logic       blk_en;
    logic       enc_valid;
    logic [3:0] enc_code;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    int idle_cyc;
    logic [8:0] got_q[$];

    adpcm_capture_sequencer_if bus ();

    adpcm_capture_sequencer #(
        .PDM_DIV    (4),
        .DECIM      (8),
        .WARMUP     (2),
        .FRAME_LEN  (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .pdm_clk_out (pdm_clk_out),
        .pdm_clk_en  (pdm_clk_en),
        .dec_strobe  (dec_strobe),
        .blk_en      (blk_en),
        .enc_valid   (enc_valid),
        .enc_code    (enc_code),
        .overflow    (overflow),
        .out_bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted output byte as {last, data}
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            got_q.push_back({bus.out_last, bus.out_data});
            last_pop_cyc <= cyc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_code(input logic [3:0] c);
        enc_valid = 1'b1;
        enc_code  = c;
        tick();
        enc_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            tick();
        end
        check_val("idle_wait", 32'(busy), 32'h0);
    endtask

    task automatic check_queue(input string tag, input int idx, input logic [8:0] exp);
        logic [8:0] v;
        v = (idx < got_q.size()) ? got_q[idx] : 9'h1FF;
        check_val($sformatf("%s[%0d]", tag, idx), 32'(v), 32'(exp));
    endtask

    logic [8:0] exp4 [4];
    logic [8:0] exp_pad [3];
    logic [8:0] exp6 [4];

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; enc_valid = 1'b0; enc_code = 4'h0;
        bus.out_ready = 1'b0;
        exp4    = '{9'h021, 9'h043, 9'h065, 9'h187};
        exp_pad = '{9'h000, 9'h000, 9'h100};
        exp6    = '{9'h021, 9'h003, 9'h000, 9'h100};

        // 1. reset values
        tick(); tick(); rst = 1'b0;
        check_val("rst_busy",    32'(busy),          32'h0);
        check_val("rst_pdm_out", 32'(pdm_clk_out),   32'h0);
        check_val("rst_pdm_en",  32'(pdm_clk_en),    32'h0);
        check_val("rst_dec",     32'(dec_strobe),    32'h0);
        check_val("rst_blk_en",  32'(blk_en),        32'h0);
        check_val("rst_valid",   32'(bus.out_valid), 32'h0);
        check_val("rst_data",    32'(bus.out_data),  32'h0);
        check_val("rst_last",    32'(bus.out_last),  32'h0);
        check_val("rst_ovf",     32'(overflow),      32'h0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check_val("startstop_busy", 32'(busy),   32'h0);
        check_val("startstop_blk",  32'(blk_en), 32'h0);
        tick();
        check_val("startstop_busy2", 32'(busy), 32'h0);

        // 2. divider and decimation timing, start accepted in cycle 0
        pulse_start();
        for (int k = 1; k <= 66; k++) begin
            check_val($sformatf("pdm_en@%0d", k),  32'(pdm_clk_en),  32'((k % 4) == 0));
            check_val($sformatf("pdm_out@%0d", k), 32'(pdm_clk_out), 32'(((k % 4) == 1) || ((k % 4) == 2)));
            check_val($sformatf("dec@%0d", k),     32'(dec_strobe),  32'((k == 32) || (k == 64)));
            check_val($sformatf("blk_en@%0d", k),  32'(blk_en),      32'h1);
            tick();
        end
        stop = 1'b1; tick(); stop = 1'b0;
        check_val("t2_stop_blk", 32'(blk_en),      32'h0);
        check_val("t2_stop_pdm", 32'(pdm_clk_out), 32'h0);
        wait_idle();

        // 3. warm-up discard and packing
        do_reset();
        bus.out_ready = 1'b0;
        pulse_start();
        send_code(4'hF); send_code(4'hF); send_code(4'h3);
        check_val("t3_none_yet", 32'(bus.out_valid), 32'h0);
        send_code(4'hA);
        check_val("t3_valid", 32'(bus.out_valid), 32'h1);
        check_val("t3_data",  32'(bus.out_data),  32'hA3);
        check_val("t3_last",  32'(bus.out_last),  32'h0);
        bus.out_ready = 1'b1;
        tick();
        check_queue("t3_pop", 0, 9'h0A3);
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle();

        // 4. framing with free-flowing output
        do_reset();
        bus.out_ready = 1'b1;
        pulse_start();
        send_code(4'hF); send_code(4'hF);
        for (int c = 1; c <= 8; c++) send_code(4'(c));
        tick(); tick();
        check_val("t4_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_queue("t4_byte", i, exp4[i]);
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle();

        // 5. backpressure and overflow
        do_reset();
        bus.out_ready = 1'b0;
        pulse_start();
        send_code(4'hF); send_code(4'hF);
        for (int c = 1; c <= 10; c++) send_code(4'(c));
        check_val("t5_ovf",   32'(overflow),      32'h1);
        check_val("t5_head",  32'(bus.out_data),  32'h21);
        check_val("t5_empty_q", 32'(got_q.size()), 32'd0);
        bus.out_ready = 1'b1;
        repeat (6) tick();
        check_val("t5_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_queue("t5_byte", i, exp4[i]);
        got_q.delete();
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle();
        tick();
        check_val("t5_pad_count", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) check_queue("t5_pad", i, exp_pad[i]);
        check_val("t5_ovf_sticky", 32'(overflow), 32'h1);
        pulse_start();
        check_val("t5_ovf_clr",   32'(overflow), 32'h0);
        check_val("t5_busy_again", 32'(busy),    32'h1);
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle();

        // 6. stop mid-frame with padding
        do_reset();
        bus.out_ready = 1'b1;
        pulse_start();
        send_code(4'hF); send_code(4'hF);
        send_code(4'h1); send_code(4'h2); send_code(4'h3);
        stop = 1'b1; tick(); stop = 1'b0;
        check_val("t6_blk_off", 32'(blk_en),      32'h0);
        check_val("t6_pdm_off", 32'(pdm_clk_out), 32'h0);
        check_val("t6_busy",    32'(busy),        32'h1);
        wait_idle();
        idle_cyc = cyc;
        check_val("t6_busy_fall", 32'(idle_cyc - last_pop_cyc), 32'd1);
        check_val("t6_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_queue("t6_byte", i, exp6[i]);
        check_val("t6_valid_end", 32'(bus.out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
